cylon_led_top: RTL and testbench

//  Top-level "Cylon" LED scanner for a 16-LED board. A lit dot sweeps across led[15:0].
//  It either bounces between the ends or wraps around. Speed is set by switches.
//  Run/pause, mode and direction are set by four debounced push-buttons.

---
 rtl/cylon_led_top_if.sv | 30 +++
 rtl/cylon_led_top.sv | 176 +++++++++++++++++
 tb/tb_cylon_led_top.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cylon_led_top_if.sv
// Board-facing signal bundle for the Cylon LED scanner: speed switches,
// raw push-buttons, the one-hot LED display and a read-only debug view of
// the scanner state (position, direction, mode, run flag).
// There is no valid/ready handshake on this bundle: the switches and buttons
// are level inputs sampled every clock, and led/dbg_* are registered levels
// that are valid on every cycle after reset.
interface cylon_led_top_if;
  logic [3:0]  sw;
  logic        btnC;
  logic        btnU;
  logic        btnL;
  logic        btnR;
  logic [15:0] led;
  logic [3:0]  dbg_pos;
  logic        dbg_dir;
  logic        dbg_mode;
  logic        dbg_run;

  // Board / stimulus side
  modport master (
    output sw, btnC, btnU, btnL, btnR,
    input  led, dbg_pos, dbg_dir, dbg_mode, dbg_run
  );

  // Scanner side
  modport slave (
    input  sw, btnC, btnU, btnL, btnR,
    output led, dbg_pos, dbg_dir, dbg_mode, dbg_run
  );
endinterface

// File: rtl/cylon_led_top.sv
// Cylon LED scanner: a single lit dot sweeps across led[15:0], bouncing
// between the ends or wrapping around. A free-running base pulse paces the
// sweep; sw selects one step every (sw+1) pulses. Four raw buttons are
// synchronised, debounced and edge-detected into single-cycle actions:
// C = run/pause, U = bounce/wrap, L = head toward led[15], R = toward led[0].
module cylon_led_top #(
  parameter logic [28:0] CLOCK_CYCLES_PER_PULSE  = 29'd1_000_000,
  parameter logic [28:0] CLOCK_CYCLES_PER_SECOND = 29'd100_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  cylon_led_top_if.slave bus
);

  // Debounce length is a fraction of a second, but never zero cycles.
  localparam logic [28:0] DB_SHIFT   = CLOCK_CYCLES_PER_SECOND >> 6;
  localparam logic [28:0] DB_LEN     = (DB_SHIFT == 29'd0) ? 29'd1 : DB_SHIFT;
  localparam logic [28:0] DB_LAST    = DB_LEN - 29'd1;
  localparam logic [28:0] PULSE_LAST = CLOCK_CYCLES_PER_PULSE - 29'd1;

  // Button bit positions inside the 4-bit button vectors.
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;

  typedef enum logic { DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1 } dir_e;
  typedef enum logic { MODE_BOUNCE = 1'b0, MODE_WRAP = 1'b1 } mode_e;

  logic [3:0]        btn_raw;

  logic [3:0]        sync1_q, sync1_d;
  logic [3:0]        sync2_q, sync2_d;
  logic [3:0]        db_level_q, db_level_d;
  logic [3:0][28:0]  db_cnt_q, db_cnt_d;
  logic [3:0]        db_prev_q, db_prev_d;
  logic [3:0]        btn_rise;

  logic [28:0]       pcnt_q, pcnt_d;
  logic              pulse;

  logic [3:0]        divcnt_q, divcnt_d;
  logic              step;

  logic [3:0]        pos_q, pos_d;
  dir_e              dir_q, dir_d;
  mode_e             mode_q, mode_d;
  logic              run_q, run_d;
  logic [15:0]       led_q, led_d;
  logic              reversed;

  assign btn_raw = {bus.btnR, bus.btnL, bus.btnU, bus.btnC};

  // Two-flop synchroniser and debouncer: the debounced level only follows
  // the synchronised input once it has differed for DB_LEN straight cycles.
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    db_level_d = db_level_q;
    db_cnt_d   = db_cnt_q;
    db_prev_d  = db_level_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == db_level_q[i]) begin
        db_cnt_d[i] = 29'd0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_level_d[i] = sync2_q[i];
        db_cnt_d[i]   = 29'd0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 29'd1;
      end
    end
    btn_rise = db_level_q & ~db_prev_q;
  end

  // Free-running base pulse and the run-gated step divider.
  always_comb begin
    pulse    = (pcnt_q == PULSE_LAST);
    pcnt_d   = pulse ? 29'd0 : (pcnt_q + 29'd1);
    step     = pulse && run_q && (divcnt_q >= bus.sw);
    divcnt_d = divcnt_q;
    if (pulse && run_q) begin
      divcnt_d = (divcnt_q >= bus.sw) ? 4'd0 : (divcnt_q + 4'd1);
    end
  end

  // Next position/direction/mode/run. A step always moves with the old
  // direction; a button direction change then applies unless the step itself
  // just bounced off an end, in which case the bounce direction is kept.
  always_comb begin
    pos_d    = pos_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    run_d    = run_q;
    reversed = 1'b0;

    if (step) begin
      if (mode_q == MODE_BOUNCE) begin
        if (dir_q == DIR_LEFT) begin
          if (pos_q == 4'd15) begin
            dir_d    = DIR_RIGHT;
            pos_d    = 4'd14;
            reversed = 1'b1;
          end else begin
            pos_d = pos_q + 4'd1;
          end
        end else begin
          if (pos_q == 4'd0) begin
            dir_d    = DIR_LEFT;
            pos_d    = 4'd1;
            reversed = 1'b1;
          end else begin
            pos_d = pos_q - 4'd1;
          end
        end
      end else begin
        pos_d = (dir_q == DIR_LEFT) ? (pos_q + 4'd1) : (pos_q - 4'd1);
      end
    end

    if (!reversed) begin
      if (btn_rise[BTN_L] && !btn_rise[BTN_R]) begin
        dir_d = DIR_LEFT;
      end else if (btn_rise[BTN_R] && !btn_rise[BTN_L]) begin
        dir_d = DIR_RIGHT;
      end
    end

    if (btn_rise[BTN_U]) begin
      mode_d = (mode_q == MODE_BOUNCE) ? MODE_WRAP : MODE_BOUNCE;
    end

    if (btn_rise[BTN_C]) begin
      run_d = ~run_q;
    end

    led_d = 16'h0001 << pos_d;
  end

  // State registers; reset parks the dot at led[0], sweeping left, bouncing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 4'd0;
      sync2_q    <= 4'd0;
      db_level_q <= 4'd0;
      db_cnt_q   <= '0;
      db_prev_q  <= 4'd0;
      pcnt_q     <= 29'd0;
      divcnt_q   <= 4'd0;
      pos_q      <= 4'd0;
      dir_q      <= DIR_LEFT;
      mode_q     <= MODE_BOUNCE;
      run_q      <= 1'b1;
      led_q      <= 16'h0001;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      db_prev_q  <= db_prev_d;
      pcnt_q     <= pcnt_d;
      divcnt_q   <= divcnt_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      mode_q     <= mode_d;
      run_q      <= run_d;
      led_q      <= led_d;
    end
  end

  assign bus.led      = led_q;
  assign bus.dbg_pos  = pos_q;
  assign bus.dbg_dir  = dir_q;
  assign bus.dbg_mode = mode_q;
  assign bus.dbg_run  = run_q;

endmodule

// File: tb/tb_cylon_led_top.sv
// Bench for the Cylon LED scanner. Uses a short base pulse (10 clks) and a
// 448 clk/s "second" so the debounce is 7 clks; with sw=7 the dot moves
// every 80 clks, with sw=0 every 10 clks.
module tb_cylon_led_top;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cylon_led_top_if bus();

  cylon_led_top #(
    .CLOCK_CYCLES_PER_PULSE (29'd10),
    .CLOCK_CYCLES_PER_SECOND(29'd448)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_chg = 0;
  logic [15:0] exp_q[$];

  // Clock/cycle bookkeeping
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: mask bits {R,L,U,C}, held for hi cycles then released for lo cycles.
  task automatic press(input logic [3:0] m, input int hi, input int lo);
    @(negedge clk);
    {bus.btnR, bus.btnL, bus.btnU, bus.btnC} = m;
    repeat (hi) @(negedge clk);
    {bus.btnR, bus.btnL, bus.btnU, bus.btnC} = 4'b0000;
    repeat (lo) @(negedge clk);
  endtask

  // Scoreboard: queue the expected led value, wait (bounded) for the display
  // to move, then pop and compare. exp_iv > 0 also checks the step spacing.
  task automatic expect_step(input string tag, input logic [15:0] exp, input int exp_iv);
    logic [15:0] old;
    logic [15:0] e;
    int n;
    exp_q.push_back(exp);
    old = bus.led;
    n = 0;
    while (bus.led === old && n < 3000) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    check(tag, 32'(bus.led), 32'(e));
    if (exp_iv > 0) check($sformatf("%s_iv", tag), 32'(cyc - last_chg), 32'(exp_iv));
    last_chg = cyc;
  endtask

  initial begin
    logic [15:0] v;
    bus.sw = 4'd7;
    {bus.btnR, bus.btnL, bus.btnU, bus.btnC} = 4'b0000;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_led",  32'(bus.led), 32'h0001);
    check("rst_pos",  32'(bus.dbg_pos), 32'd0);
    check("rst_dir",  32'(bus.dbg_dir), 32'd0);
    check("rst_mode", 32'(bus.dbg_mode), 32'd0);
    check("rst_run",  32'(bus.dbg_run), 32'd1);
    rst_n = 1'b1;

    // Basic sweep
    expect_step("s1_0002", 16'h0002, 0);
    expect_step("s1_0004", 16'h0004, 80);

    // Mode to WRAP without disturbing the dot, then wrap 15 -> 0
    press(4'b0010, 20, 12);
    check("wrap_no_glitch", 32'(bus.led), 32'h0004);
    check("wrap_mode", 32'(bus.dbg_mode), 32'd1);
    for (int p = 3; p < 16; p++) begin
      v = 16'h0001 << p;
      expect_step($sformatf("wrap_p%0d", p), v, 80);
    end
    expect_step("wrap_to0", 16'h0001, 80);

    // Back to BOUNCE, fast speed, bounce off the top end
    press(4'b0010, 20, 12);
    check("bounce_mode", 32'(bus.dbg_mode), 32'd0);
    bus.sw = 4'd0;
    expect_step("fast_first", 16'h0002, 0);
    for (int p = 2; p < 16; p++) begin
      v = 16'h0001 << p;
      expect_step($sformatf("fast_p%0d", p), v, 10);
    end
    expect_step("bounce_4000", 16'h4000, 10);
    expect_step("bounce_2000", 16'h2000, 10);
    check("bounce_dir", 32'(bus.dbg_dir), 32'd1);

    // Pause with a long hold (no auto-repeat), ignore a glitch, resume
    bus.sw = 4'd7;
    press(4'b0001, 200, 12);
    check("pause_run", 32'(bus.dbg_run), 32'd0);
    repeat (600) @(negedge clk);
    check("pause_led", 32'(bus.led), 32'h2000);
    press(4'b0001, 3, 20);
    check("glitch_run", 32'(bus.dbg_run), 32'd0);
    check("glitch_led", 32'(bus.led), 32'h2000);
    press(4'b0001, 20, 12);
    check("resume_run", 32'(bus.dbg_run), 32'd1);
    expect_step("resume_1000", 16'h1000, 0);
    expect_step("resume_0800", 16'h0800, 80);

    // Direction buttons
    press(4'b0100, 20, 12);
    check("btnL_dir", 32'(bus.dbg_dir), 32'd0);
    expect_step("left_1000", 16'h1000, 80);
    press(4'b1000, 20, 12);
    check("btnR_dir", 32'(bus.dbg_dir), 32'd1);
    expect_step("right_0800", 16'h0800, 80);
    expect_step("right_0400", 16'h0400, 80);
    press(4'b1100, 20, 12);
    check("both_dir", 32'(bus.dbg_dir), 32'd1);
    expect_step("both_0200", 16'h0200, 80);

    // Asynchronous reset mid-sweep after changing mode and run
    press(4'b0010, 20, 12);
    press(4'b0001, 20, 12);
    check("pre_rst_mode", 32'(bus.dbg_mode), 32'd1);
    check("pre_rst_run",  32'(bus.dbg_run), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_led",  32'(bus.led), 32'h0001);
    check("arst_pos",  32'(bus.dbg_pos), 32'd0);
    check("arst_dir",  32'(bus.dbg_dir), 32'd0);
    check("arst_mode", 32'(bus.dbg_mode), 32'd0);
    check("arst_run",  32'(bus.dbg_run), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_step("post_rst_0002", 16'h0002, 0);
    expect_step("post_rst_0004", 16'h0004, 80);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
